// File: rtl/ysyx_25040109_pkg.sv
// Shared definitions for the ysyx_25040109 core: fetch FSM encoding,
// fetch error codes, reset PC and AXI response codes.
package ysyx_25040109_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AR   = 3'd1,
        S_R    = 3'd2,
        S_OUT  = 3'd3,
        S_WB   = 3'd4
    } ifu_state_t;

    localparam logic [1:0] FE_OK       = 2'b00;
    localparam logic [1:0] FE_BUS      = 2'b01;
    localparam logic [1:0] FE_MISALIGN = 2'b10;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/ysyx_25040109_fetch_unit.sv
// Multi-cycle instruction fetch unit. Owns the architectural PC, fetches one
// instruction at a time over an AXI4-Lite read channel, hands it to decode
// with a valid/ready handshake and then waits for writeback to supply the
// next PC. Misaligned PCs are reported without touching the bus.
module ysyx_25040109_fetch_unit #(
    parameter int                 ADDR_W   = 32,
    parameter int                 DATA_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = ysyx_25040109_pkg::RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] pc,
    output logic [1:0]        fetch_err,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_next_pc,
    input  logic              stall,
    output logic [31:0]       inst_cnt
);

    import ysyx_25040109_pkg::*;

    ifu_state_t state;

    // Handshake outputs are pure state decodes, so inst_ready and wb_valid
    // can never reach the AXI side combinationally.
    assign arvalid    = (state == S_AR);
    assign rready     = (state == S_R);
    assign inst_valid = (state == S_OUT);
    assign araddr     = pc;

    // Fetch FSM together with the PC, instruction, error and retire counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            pc        <= RESET_PC;
            inst      <= '0;
            fetch_err <= FE_OK;
            inst_cnt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!stall) begin
                        if (pc[1:0] != 2'b00) begin
                            inst      <= '0;
                            fetch_err <= FE_MISALIGN;
                            state     <= S_OUT;
                        end else begin
                            state <= S_AR;
                        end
                    end
                end
                S_AR: begin
                    if (arready) begin
                        state <= S_R;
                    end
                end
                S_R: begin
                    if (rvalid) begin
                        inst      <= rdata;
                        fetch_err <= (rresp != RESP_OKAY) ? FE_BUS : FE_OK;
                        state     <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (inst_ready) begin
                        inst_cnt <= inst_cnt + 32'd1;
                        state    <= S_WB;
                    end
                end
                S_WB: begin
                    if (wb_valid) begin
                        pc <= wb_next_pc;
                        if (stall) begin
                            state <= S_IDLE;
                        end else if (wb_next_pc[1:0] != 2'b00) begin
                            inst      <= '0;
                            fetch_err <= FE_MISALIGN;
                            state     <= S_OUT;
                        end else begin
                            state <= S_AR;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_25040109_fetch_unit.sv
// Directed self-checking bench for the fetch unit. Inputs are driven and
// outputs sampled 1 ns after each rising clock edge.
module tb_ysyx_25040109_fetch_unit;

    logic        clk;
    logic        rst;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [1:0]  fetch_err;
    logic        wb_valid;
    logic [31:0] wb_next_pc;
    logic        stall;
    logic [31:0] inst_cnt;

    int checks = 0;
    int errors = 0;
    int ar_hs  = 0;

    ysyx_25040109_fetch_unit dut (
        .clk        (clk),
        .rst        (rst),
        .araddr     (araddr),
        .arvalid    (arvalid),
        .arready    (arready),
        .rdata      (rdata),
        .rresp      (rresp),
        .rvalid     (rvalid),
        .rready     (rready),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst       (inst),
        .pc         (pc),
        .fetch_err  (fetch_err),
        .wb_valid   (wb_valid),
        .wb_next_pc (wb_next_pc),
        .stall      (stall),
        .inst_cnt   (inst_cnt)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count AR handshakes seen at each rising edge
    always @(posedge clk) begin
        if (!rst && arvalid && arready) ar_hs = ar_hs + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
        inst_ready = 1'b0; wb_valid = 1'b0; wb_next_pc = '0; stall = 1'b0;
        tick(); tick();
        checks++; if (arvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_arvalid got %b expected 0", arvalid); end
        checks++; if (rready !== 1'b0) begin errors++; $display("[TB] FAIL reset_rready got %b expected 0", rready); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_inst_valid got %b expected 0", inst_valid); end
        checks++; if (pc !== 32'h8000_0000) begin errors++; $display("[TB] FAIL reset_pc got %h expected 80000000", pc); end
        checks++; if (inst !== 32'h0) begin errors++; $display("[TB] FAIL reset_inst got %h expected 00000000", inst); end
        checks++; if (fetch_err !== 2'b00) begin errors++; $display("[TB] FAIL reset_err got %b expected 00", fetch_err); end
        checks++; if (inst_cnt !== 32'd0) begin errors++; $display("[TB] FAIL reset_cnt got %0d expected 0", inst_cnt); end
    endtask

    task automatic test_basic_fetch();
        arready = 1'b1; rvalid = 1'b1; rdata = 32'h0000_0413; rresp = 2'b00;
        rst = 1'b0;
        tick();
        checks++; if (arvalid !== 1'b1) begin errors++; $display("[TB] FAIL basic_arvalid got %b expected 1", arvalid); end
        checks++; if (araddr !== 32'h8000_0000) begin errors++; $display("[TB] FAIL basic_araddr got %h expected 80000000", araddr); end
        tick();
        checks++; if (rready !== 1'b1 || inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_r_state got rready=%b inst_valid=%b expected 1/0", rready, inst_valid); end
        tick();
        arready = 1'b0; rvalid = 1'b0;
        checks++; if (inst_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_inst_valid got %b expected 1", inst_valid); end
        checks++; if (inst !== 32'h0000_0413) begin errors++; $display("[TB] FAIL basic_inst got %h expected 00000413", inst); end
        checks++; if (fetch_err !== 2'b00) begin errors++; $display("[TB] FAIL basic_err got %b expected 00", fetch_err); end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        checks++; if (inst_cnt !== 32'd1 || inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_accept got cnt=%0d valid=%b expected 1/0", inst_cnt, inst_valid); end
        wb_valid = 1'b1; wb_next_pc = 32'h8000_0004;
        tick();
        wb_valid = 1'b0;
        checks++; if (arvalid !== 1'b1 || araddr !== 32'h8000_0004) begin errors++; $display("[TB] FAIL basic_next_ar got arvalid=%b araddr=%h expected 1/80000004", arvalid, araddr); end
    endtask

    task automatic test_ar_backpressure();
        int hs_start;
        hs_start = ar_hs;
        for (int i = 0; i < 5; i++) begin
            stall = (i == 2 || i == 3);
            tick();
            checks++; if (arvalid !== 1'b1 || araddr !== 32'h8000_0004) begin errors++; $display("[TB] FAIL ar_hold_%0d got arvalid=%b araddr=%h expected 1/80000004", i, arvalid, araddr); end
        end
        stall = 1'b0;
        arready = 1'b1;
        tick();
        checks++; if (rready !== 1'b1 || arvalid !== 1'b0) begin errors++; $display("[TB] FAIL ar_to_r got rready=%b arvalid=%b expected 1/0", rready, arvalid); end
        tick(); tick();
        arready = 1'b0;
        checks++; if (ar_hs - hs_start !== 1) begin errors++; $display("[TB] FAIL ar_single_hs got %0d expected 1", ar_hs - hs_start); end
        rvalid = 1'b1; rdata = 32'h0010_0093;
        tick();
        rvalid = 1'b0;
    endtask

    task automatic test_out_backpressure();
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (inst_valid !== 1'b1 || inst !== 32'h0010_0093 || pc !== 32'h8000_0004 || inst_cnt !== 32'd1) begin
                errors++; $display("[TB] FAIL out_hold_%0d got valid=%b inst=%h pc=%h cnt=%0d expected 1/00100093/80000004/1", i, inst_valid, inst, pc, inst_cnt);
            end
        end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        checks++; if (inst_cnt !== 32'd2 || inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL out_accept got cnt=%0d valid=%b expected 2/0", inst_cnt, inst_valid); end
        tick();
        checks++; if (inst_cnt !== 32'd2) begin errors++; $display("[TB] FAIL out_cnt_once got %0d expected 2", inst_cnt); end
    endtask

    task automatic test_wb_stall();
        wb_valid = 1'b1; wb_next_pc = 32'h8000_0010; stall = 1'b1;
        tick();
        wb_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin wb_valid = 1'b1; wb_next_pc = 32'h9000_0000; end
            else wb_valid = 1'b0;
            tick();
            checks++; if (arvalid !== 1'b0 || inst_valid !== 1'b0 || pc !== 32'h8000_0010) begin
                errors++; $display("[TB] FAIL stall_idle_%0d got arvalid=%b valid=%b pc=%h expected 0/0/80000010", i, arvalid, inst_valid, pc);
            end
        end
        wb_valid = 1'b0;
        stall = 1'b0;
        tick();
        checks++; if (arvalid !== 1'b1 || araddr !== 32'h8000_0010) begin errors++; $display("[TB] FAIL stall_release got arvalid=%b araddr=%h expected 1/80000010", arvalid, araddr); end
    endtask

    task automatic test_errors();
        int hs_start;
        arready = 1'b1;
        tick();
        arready = 1'b0;
        rvalid = 1'b1; rdata = 32'hdead_beef; rresp = 2'b10;
        tick();
        rvalid = 1'b0; rresp = 2'b00;
        checks++; if (inst_valid !== 1'b1 || fetch_err !== 2'b01) begin errors++; $display("[TB] FAIL bus_err got valid=%b err=%b expected 1/01", inst_valid, fetch_err); end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        hs_start = ar_hs;
        arready = 1'b1;
        wb_valid = 1'b1; wb_next_pc = 32'h8000_0002; stall = 1'b0;
        tick();
        wb_valid = 1'b0;
        checks++; if (inst_valid !== 1'b1 || fetch_err !== 2'b10 || inst !== 32'h0 || arvalid !== 1'b0 || pc !== 32'h8000_0002) begin
            errors++; $display("[TB] FAIL misalign_wb got valid=%b err=%b inst=%h arvalid=%b pc=%h expected 1/10/00000000/0/80000002", inst_valid, fetch_err, inst, arvalid, pc);
        end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        checks++; if (inst_cnt !== 32'd4) begin errors++; $display("[TB] FAIL misalign_cnt got %0d expected 4", inst_cnt); end
        wb_valid = 1'b1; wb_next_pc = 32'h8000_0006; stall = 1'b1;
        tick();
        wb_valid = 1'b0; stall = 1'b0;
        tick();
        checks++; if (inst_valid !== 1'b1 || fetch_err !== 2'b10 || pc !== 32'h8000_0006 || arvalid !== 1'b0) begin
            errors++; $display("[TB] FAIL misalign_idle got valid=%b err=%b pc=%h arvalid=%b expected 1/10/80000006/0", inst_valid, fetch_err, pc, arvalid);
        end
        checks++; if (ar_hs !== hs_start) begin errors++; $display("[TB] FAIL misalign_no_ar got %0d expected %0d", ar_hs, hs_start); end
        arready = 1'b0;
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        wb_valid = 1'b1; wb_next_pc = 32'h8000_0020;
        tick();
        wb_valid = 1'b0;
    endtask

    task automatic test_reset_midflight();
        arready = 1'b1;
        tick();
        arready = 1'b0;
        checks++; if (rready !== 1'b1) begin errors++; $display("[TB] FAIL mid_in_r got %b expected 1", rready); end
        rst = 1'b1;
        tick();
        checks++; if (arvalid !== 1'b0 || rready !== 1'b0 || inst_valid !== 1'b0 || pc !== 32'h8000_0000 || inst_cnt !== 32'd0) begin
            errors++; $display("[TB] FAIL mid_reset got arvalid=%b rready=%b valid=%b pc=%h cnt=%0d expected 0/0/0/80000000/0", arvalid, rready, inst_valid, pc, inst_cnt);
        end
        rst = 1'b0;
        tick();
        checks++; if (arvalid !== 1'b1 || araddr !== 32'h8000_0000) begin errors++; $display("[TB] FAIL mid_restart_ar got arvalid=%b araddr=%h expected 1/80000000", arvalid, araddr); end
        arready = 1'b1;
        tick();
        arready = 1'b0;
        rvalid = 1'b1; rdata = 32'h0000_0013;
        tick();
        rvalid = 1'b0;
        checks++; if (inst_valid !== 1'b1 || inst !== 32'h0000_0013 || fetch_err !== 2'b00) begin
            errors++; $display("[TB] FAIL mid_restart_inst got valid=%b inst=%h err=%b expected 1/00000013/00", inst_valid, inst, fetch_err);
        end
    endtask

    // Run every scenario in order, then report
    initial begin
        test_reset();
        test_basic_fetch();
        test_ar_backpressure();
        test_out_backpressure();
        test_wb_stall();
        test_errors();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
